// File: rtl/debug_uart_tx_pkg.sv
// Shared UART definitions: state encodings, oversample factor and the default
// baud divider. The matching receiver imports the same package.
package debug_uart_tx_pkg;

  // Oversample ticks per bit and the width of a counter covering 0..UART_OVS-1.
  localparam int UART_OVS         = 16;
  localparam int UART_TICK_W      = $clog2(UART_OVS);

  // 50 MHz / (9600 baud * 16 oversample).
  localparam int UART_DIVISOR_DEF = 326;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // True when an oversample tick counter sits on the last tick of a len-tick span.
  function automatic logic tick_last(input logic [UART_TICK_W-1:0] cnt, input int len);
    return cnt == UART_TICK_W'(len - 1);
  endfunction

endpackage

// File: rtl/debug_uart_tx_if.sv
// Byte interface between the debug FSM (master) and the UART transmitter (slave).
interface debug_uart_tx_if #(
  parameter int DBIT = 8
);

  logic [DBIT-1:0] i_tx_data;
  logic            is_tx_start;
  logic            o_tx;
  logic            o_tx_busy;
  logic            os_tx_done;

  modport master (
    output i_tx_data, is_tx_start,
    input  o_tx, o_tx_busy, os_tx_done
  );

  modport slave (
    input  i_tx_data, is_tx_start,
    output o_tx, o_tx_busy, os_tx_done
  );

endinterface

// File: rtl/debug_uart_tx_baud_tick.sv
// Oversample tick generator: counts 0..DIVISOR-1 and flags the last count.
// i_clear restarts the count so a frame always begins on a fresh tick period.
module uart_baud_tick
  import debug_uart_tx_pkg::*;
#(
  parameter int DIVISOR = UART_DIVISOR_DEF,
  parameter int DIV_W   = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             at_top;

  assign at_top = (cnt_q == DIV_W'(DIVISOR - 1));
  assign o_tick = at_top;

  // Next count: clear wins, otherwise wrap at DIVISOR-1.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_clear || at_top) begin
      cnt_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// 8N1 UART transmitter for the debug unit. One byte per accepted start strobe,
// LSB first; a one-cycle done pulse in the first idle cycle after the stop bit
// paces the debug FSM. o_tx and done are registered; busy is decoded from the
// state register only.
module debug_uart_tx
  import debug_uart_tx_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DIVISOR = UART_DIVISOR_DEF,
  parameter int DIV_W   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  debug_uart_tx_if.slave        tx_if
);

  localparam int BIT_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  uart_state_e            state_q, state_d;
  logic [UART_TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DBIT-1:0]        shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   accept;
  logic                   tick;

  // The divider restarts on accept so the start bit is exactly 16 ticks long.
  uart_baud_tick #(
    .DIVISOR (DIVISOR),
    .DIV_W   (DIV_W)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .i_clear (accept),
    .o_tick  (tick)
  );

  // Frame sequencing; o_tx is computed one cycle ahead so the line is a flop.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    accept     = 1'b0;

    case (state_q)
      UART_IDLE: begin
        tx_d = 1'b1;
        if (tx_if.is_tx_start) begin
          accept     = 1'b1;
          shift_d    = tx_if.i_tx_data;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = UART_START;
          tx_d       = 1'b0;
        end
      end

      UART_START: begin
        if (tick) begin
          if (tick_last(tick_cnt_q, UART_OVS)) begin
            tick_cnt_d = '0;
            state_d    = UART_DATA;
            tx_d       = shift_q[0];
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      UART_DATA: begin
        if (tick) begin
          if (tick_last(tick_cnt_q, UART_OVS)) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            if (bit_cnt_q == BIT_W'(DBIT - 1)) begin
              state_d = UART_STOP;
              tx_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              tx_d      = shift_d[0];
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      UART_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (tick_last(tick_cnt_q, SB_TICK)) begin
            tick_cnt_d = '0;
            state_d    = UART_IDLE;
            done_d     = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = UART_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset parks the line high and drops any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= UART_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx_if.o_tx       = tx_q;
  assign tx_if.o_tx_busy  = (state_q != UART_IDLE);
  assign tx_if.os_tx_done = done_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx at DIVISOR=4: 64 clk per bit, 640 clk per frame.
// The reference describes the line as a function of cycles since accept;
// a behavioural 16x receiver decodes the line for byte-level checks.
module tb_debug_uart_tx;
  import debug_uart_tx_pkg::*;

  localparam int DIV     = 4;
  localparam int BIT_CYC = UART_OVS * DIV;
  localparam int FRAME   = 10 * BIT_CYC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_uart_tx_if u_if ();

  debug_uart_tx #(
    .DBIT    (8),
    .SB_TICK (16),
    .DIVISOR (DIV),
    .DIV_W   (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (u_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Reference: m_t counts cycles after the accept edge; frame cycles 0..639,
  // done cycle 640, after which the transmitter is idle again.
  bit         m_act  = 1'b0;
  int         m_t    = 0;
  logic [7:0] m_byte = 8'h00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act <= 1'b0;
      m_t   <= 0;
    end else if (u_if.is_tx_start && (!m_act || m_t == FRAME)) begin
      m_act  <= 1'b1;
      m_t    <= 0;
      m_byte <= u_if.i_tx_data;
    end else if (m_act) begin
      if (m_t == FRAME) m_act <= 1'b0;
      else              m_t   <= m_t + 1;
    end
  end

  function automatic logic exp_tx();
    int idx;
    if (!m_act || m_t == FRAME) return 1'b1;
    idx = m_t / BIT_CYC;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  // Cycle-by-cycle comparison against the reference.
  always @(negedge clk) begin
    chk("o_tx", u_if.o_tx, exp_tx());
    chk("o_tx_busy", u_if.o_tx_busy, m_act && m_t != FRAME);
    chk("os_tx_done", u_if.os_tx_done, m_act && m_t == FRAME);
  end

  // Event monitors: done pulses and falling edges of the line.
  int   done_cnt = 0;
  int   fall_q[$];
  logic prev_tx  = 1'b1;
  always @(negedge clk) begin
    if (u_if.os_tx_done) done_cnt <= done_cnt + 1;
    if (prev_tx && !u_if.o_tx) fall_q.push_back(cyc);
    prev_tx <= u_if.o_tx;
  end

  // Behavioural receiver: sample each bit in its middle, 32 clk after the edge.
  int         rx_t = -1;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_q[$];
  int         ferr = 0;
  always @(negedge clk) begin
    if (!rst) begin
      rx_t <= -1;
    end else if (rx_t < 0) begin
      if (!u_if.o_tx) rx_t <= 1;
    end else begin
      rx_t <= rx_t + 1;
      if (rx_t == BIT_CYC/2 && u_if.o_tx) rx_t <= -1;
      for (int k = 1; k <= 8; k++)
        if (rx_t == BIT_CYC/2 + BIT_CYC*k) rx_sh[k-1] <= u_if.o_tx;
      if (rx_t == BIT_CYC/2 + BIT_CYC*9) begin
        if (!u_if.o_tx) ferr <= ferr + 1;
        rx_q.push_back(rx_sh);
        rx_t <= -1;
      end
    end
  end

  // Called on a negedge; holds the strobe for exactly one cycle, then scrambles data.
  task automatic pulse(input logic [7:0] b);
    u_if.i_tx_data   = b;
    u_if.is_tx_start = 1'b1;
    @(negedge clk);
    u_if.is_tx_start = 1'b0;
    u_if.i_tx_data   = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    pulse(b);
  endtask

  // Returns on the negedge of the done cycle, or flags a timeout.
  task automatic wait_done(input string nm);
    int n = 0;
    while (!u_if.os_tx_done && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!u_if.os_tx_done) begin
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done", nm);
    end
  endtask

  task automatic clear_mon();
    fall_q.delete();
    rx_q.delete();
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [7:0] sent[$];
    u_if.is_tx_start = 1'b0;
    u_if.i_tx_data   = 8'h00;

    // 1: reset held 5 cycles, then a quiet line.
    #3 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_tx", u_if.o_tx, 1);
    chk("rst_busy", u_if.o_tx_busy, 0);
    chk("rst_done", u_if.os_tx_done, 0);
    #1 rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_done_cnt", done_cnt, 0);
    chk("idle_falls", fall_q.size(), 0);

    // 2: single byte A5, falling edge to done = 640 cycles.
    clear_mon();
    d0 = done_cnt;
    send(8'hA5);
    wait_done("a5");
    chk("a5_len", cyc - fall_q[0], FRAME);
    repeat (50) @(negedge clk);
    chk("a5_done_cnt", done_cnt - d0, 1);
    chk("a5_rx_n", rx_q.size(), 1);
    chk("a5_rx", rx_q[0], 8'hA5);

    // 3: 00 then FF, second strobe in the done cycle.
    clear_mon();
    d0 = done_cnt;
    send(8'h00);
    wait_done("b2b0");
    pulse(8'hFF);
    wait_done("b2b1");
    repeat (50) @(negedge clk);
    chk("b2b_gap", fall_q[1] - fall_q[0], FRAME + 1);
    chk("b2b_done_cnt", done_cnt - d0, 2);
    chk("b2b_rx0", rx_q[0], 8'h00);
    chk("b2b_rx1", rx_q[1], 8'hFF);

    // 4: strobe with 3C at cycle 200 of an 81 frame is ignored.
    clear_mon();
    d0 = done_cnt;
    send(8'h81);
    repeat (199) @(negedge clk);
    pulse(8'h3C);
    wait_done("busy");
    repeat (FRAME + 50) @(negedge clk);
    chk("busy_done_cnt", done_cnt - d0, 1);
    chk("busy_rx_n", rx_q.size(), 1);
    chk("busy_rx", rx_q[0], 8'h81);

    // 5: reset during the data bits aborts the frame.
    clear_mon();
    d0 = done_cnt;
    send(8'hC3);
    repeat (300) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_tx", u_if.o_tx, 1);
    chk("mid_rst_busy", u_if.o_tx_busy, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (FRAME + 60) @(negedge clk);
    chk("mid_rst_done_cnt", done_cnt - d0, 0);
    chk("mid_rst_rx_n", rx_q.size(), 0);
    send(8'h5A);
    wait_done("post_rst");
    repeat (50) @(negedge clk);
    chk("post_rst_rx", rx_q[0], 8'h5A);

    // 6: debug-FSM loopback, one byte per done pulse.
    clear_mon();
    for (int i = 1; i <= 8; i++) begin
      send(8'(i));
      wait_done("loop");
    end
    repeat (50) @(negedge clk);
    chk("loop_rx_n", rx_q.size(), 8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      chk("loop_rx", rx_q[i], i + 1);

    // 7: random bytes, random gaps, random strobes while busy.
    clear_mon();
    sent.delete();
    for (int f = 0; f < 6; f++) begin
      logic [7:0] b;
      b = 8'($urandom);
      sent.push_back(b);
      pulse(b);
      repeat ($urandom_range(20, 600)) @(negedge clk);
      if (u_if.o_tx_busy) pulse(8'($urandom));
      wait_done("rand");
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    repeat (50) @(negedge clk);
    chk("rand_rx_n", rx_q.size(), sent.size());
    for (int i = 0; i < sent.size() && i < rx_q.size(); i++)
      chk("rand_rx", rx_q[i], sent[i]);
    chk("framing_errors", ferr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
